// File: rtl/intr_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : intr_ctrl_pkg
// Purpose  : Shared types and helpers for the vectored interrupt controller.
//            This file holds the controller state encoding, the state typedef
//            and a one-hot decode helper.
// Revision : 1.0 - initial release
// ============================================================================
package intr_ctrl_pkg;

  localparam int MAX_NINTR = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'b001,
    ARB     = 3'b010,
    SERVICE = 3'b100
  } state_t;

  // Decodes a channel index into a maximum-width one-hot vector.
  // Callers size-cast the result down to NINTR bits.
  function automatic logic [MAX_NINTR-1:0] onehot(input logic [4:0] id);
    onehot = {{(MAX_NINTR-1){1'b0}}, 1'b1} << id;
  endfunction

endpackage
`default_nettype wire

// File: rtl/intr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : intr_arbiter
// Purpose  : Combinational winner selection over the eligible channels.
//            - INTC_ROUND_ROBIN_EN defined: the scan starts at ptr and moves
//              upward, wrapping modulo NINTR. The first set bit wins.
//            - INTC_ROUND_ROBIN_EN undefined: the highest set index wins and
//              ptr is ignored.
// Ports    : eligible [NINTR] in  - pending & mask
//            ptr      [ID_W]  in  - round-robin start index
//            winner   [ID_W]  out - selected channel index
//            valid            out - at least one channel eligible
// Revision : 1.0 - initial release
// ============================================================================
module intr_arbiter #(
  parameter  int NINTR = 8,
  localparam int ID_W  = $clog2(NINTR)
) (
  input  logic [NINTR-1:0] eligible,
  input  logic [ID_W-1:0]  ptr,
  output logic [ID_W-1:0]  winner,
  output logic             valid
);

`ifdef INTC_ROUND_ROBIN_EN
  // The index is one bit wider than needed so ptr+k can be wrapped without
  // overflowing before the compare.
  localparam logic [ID_W:0] N_WIDE = (ID_W+1)'(NINTR);

  always_comb begin
    logic [ID_W:0] sum;
    winner = '0;
    valid  = 1'b0;
    sum    = '0;
    for (int k = 0; k < NINTR; k++) begin
      sum = {1'b0, ptr} + (ID_W+1)'(k);
      if (sum >= N_WIDE) begin
        sum = sum - N_WIDE;
      end
      if (!valid && eligible[sum[ID_W-1:0]]) begin
        valid  = 1'b1;
        winner = sum[ID_W-1:0];
      end
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  // Ascending scan, so the last hit (the highest index) wins.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    for (int k = 0; k < NINTR; k++) begin
      if (eligible[k]) begin
        valid  = 1'b1;
        winner = ID_W'(k);
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: rtl/intr_ctrl_vectored.sv
`default_nettype none
// ============================================================================
// Module   : intr_ctrl_vectored
// Purpose  : Vectored interrupt controller. It provides sticky pending
//            latches, a per-channel mask, an ack/done service handshake and a
//            service-timeout watchdog. Only one interrupt is in service at a
//            time.
//            Optional feature: define INTC_ROUND_ROBIN_EN for round-robin
//            arbitration. Without it, arbitration is fixed priority.
// Ports    : clk                 in  - rising-edge clock
//            reset_n             in  - asynchronous active-low reset
//            req         [NINTR] in  - level requests
//            mask        [NINTR] in  - 1 = channel enabled for arbitration
//            done                in  - service-complete strobe
//            irq                 out - high throughout service
//            irq_id      [ID_W]  out - granted channel index
//            ack         [NINTR] out - one-hot grant
//            pending     [NINTR] out - pending register
//            timeout_err         out - one-cycle pulse on watchdog abort
// Revision : 1.0 - initial release
// ============================================================================
module intr_ctrl_vectored
  import intr_ctrl_pkg::*;
#(
  parameter  int NINTR   = 8,
  parameter  int TIMEOUT = 64,
  localparam int ID_W    = $clog2(NINTR)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [NINTR-1:0] req,
  input  logic [NINTR-1:0] mask,
  input  logic             done,
  output logic             irq,
  output logic [ID_W-1:0]  irq_id,
  output logic [NINTR-1:0] ack,
  output logic [NINTR-1:0] pending,
  output logic             timeout_err
);

  // The timer is kept at least one bit wide so that TIMEOUT=0, which
  // disables the watchdog, still elaborates.
  localparam int              TMR_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NINTR - 1);

  state_t           state;
  logic [TMR_W-1:0] timer;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  win_id;
  logic             win_valid;
  logic [NINTR-1:0] win_oh;
  logic [NINTR-1:0] eligible;
  logic [NINTR-1:0] clr;

  assign eligible = pending & mask;
  assign win_oh   = NINTR'(onehot(5'(win_id)));
  // The clear applies only on the edge that performs the grant. Any
  // coincident request re-sets the bit because it is ORed in afterwards.
  assign clr      = (state == ARB && win_valid) ? win_oh : '0;

  intr_arbiter #(
    .NINTR (NINTR)
  ) u_arbiter (
    .eligible (eligible),
    .ptr      (ptr),
    .winner   (win_id),
    .valid    (win_valid)
  );

`ifdef INTC_ROUND_ROBIN_EN
  logic [ID_W-1:0] rr_ptr;
  assign ptr = rr_ptr;
`else
  assign ptr = '0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      timer       <= '0;
      irq         <= 1'b0;
      irq_id      <= '0;
      ack         <= '0;
      pending     <= '0;
      timeout_err <= 1'b0;
`ifdef INTC_ROUND_ROBIN_EN
      rr_ptr      <= '0;
`endif
    end else begin
      timeout_err <= 1'b0;
      pending     <= (pending & ~clr) | req;
      case (state)
        IDLE: begin
          if (|eligible) begin
            state <= ARB;
          end
        end
        ARB: begin
          // Eligibility may have vanished since IDLE, for example if the
          // mask dropped. In that case go back without a grant.
          if (win_valid) begin
            state  <= SERVICE;
            irq    <= 1'b1;
            irq_id <= win_id;
            ack    <= win_oh;
            timer  <= '0;
          end else begin
            state <= IDLE;
          end
        end
        SERVICE: begin
          // done takes precedence over a coincident watchdog expiry.
          if (done || (TIMEOUT != 0 && timer == TMR_LAST)) begin
            state       <= IDLE;
            irq         <= 1'b0;
            ack         <= '0;
            timeout_err <= !done;
`ifdef INTC_ROUND_ROBIN_EN
            rr_ptr      <= (irq_id == ID_LAST) ? '0 : irq_id + 1'b1;
`endif
          end else begin
            timer <= timer + TMR_ONE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_intr_ctrl_vectored.sv
`default_nettype none
// ============================================================================
// Module   : tb_intr_ctrl_vectored
// Purpose  : Self-checking bench for intr_ctrl_vectored. A behavioural model
//            predicts each grant and pushes it into a scoreboard queue. A
//            monitor pops an entry on every irq rise and compares the output
//            lines once per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_intr_ctrl_vectored;

  localparam int N  = 8;
  localparam int TO = 4;
  localparam int IW = $clog2(N);

  logic          clk = 1'b0;
  logic          reset_n;
  logic [N-1:0]  req;
  logic [N-1:0]  mask;
  logic          done;
  logic          irq;
  logic [IW-1:0] irq_id;
  logic [N-1:0]  ack;
  logic [N-1:0]  pending;
  logic          timeout_err;

  int total = 0;
  int bad   = 0;

  intr_ctrl_vectored #(.NINTR(N), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (req),
    .mask        (mask),
    .done        (done),
    .irq         (irq),
    .irq_id      (irq_id),
    .ack         (ack),
    .pending     (pending),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The model tracks how many edges remain before a grant happens, which
  // channel is in service, and how long that channel has been served.
  int       exp_grant[$];
  bit [N-1:0] m_pend;
  bit       m_serving;
  bit       m_arb_next;
  int       m_id, m_age, m_rr;
  bit       m_toerr;

  function automatic int pick(input bit [N-1:0] e, input int start);
`ifdef INTC_ROUND_ROBIN_EN
    for (int k = 0; k < N; k++) if (e[(start + k) % N]) return (start + k) % N;
`else
    for (int k = N - 1; k >= 0; k--) if (e[k]) return k;
`endif
    return -1;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_pend = '0; m_serving = 0; m_arb_next = 0;
      m_id = 0; m_age = 0; m_rr = 0; m_toerr = 0;
      exp_grant.delete();
    end else begin
      bit [N-1:0] clr;
      int w;
      clr = '0;
      m_toerr = 0;
      if (m_serving) begin
        if (done || m_age == TO - 1) begin
          m_toerr   = !done;
          m_serving = 0;
          m_rr      = (m_id + 1) % N;
        end else begin
          m_age++;
        end
      end else if (m_arb_next) begin
        m_arb_next = 0;
        w = pick(m_pend & mask, m_rr);
        if (w >= 0) begin
          m_serving = 1; m_id = w; m_age = 0;
          clr[w] = 1'b1;
          exp_grant.push_back(w);
        end
      end else if ((m_pend & mask) != 0) begin
        m_arb_next = 1;
      end
      m_pend = (m_pend & ~clr) | req;
    end
  end

  // ---------------- monitor ----------------
  bit prev_irq = 0;
  int cur_id   = 0;

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_irq = 0;
    end else begin
      chk("irq", irq, m_serving);
      chk("pending", pending, m_pend);
      chk("timeout_err", timeout_err, m_toerr);
      if (irq && !prev_irq) begin
        if (exp_grant.size() == 0) begin
          chk("unexpected_grant", 1, 0);
        end else begin
          cur_id = exp_grant.pop_front();
          chk("irq_id", irq_id, cur_id);
        end
      end
      if (irq) chk("ack", ack, 32'd1 << cur_id);
      else     chk("ack_idle", ack, 0);
      prev_irq = irq;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0; req = '0; mask = '1; done = 1'b0;
    #1;
    chk("rst_irq", irq, 0);
    chk("rst_ack", ack, 0);
    chk("rst_pending", pending, 0);
    chk("rst_irq_id", irq_id, 0);
    chk("rst_timeout_err", timeout_err, 0);
    repeat (3) step();
    reset_n = 1'b1;

    // Single request on channel 3, done issued after the grant.
    step(); req = 8'h08;
    step(); req = '0;
    repeat (3) step();
    done = 1'b1; step(); done = 1'b0;
    repeat (3) step();

    // Two simultaneous requests; one service then times out.
    req = 8'h24; step(); req = '0;
    repeat (12) step();

    // A masked request is held, then released.
    mask = 8'hBF; req = 8'h40; step(); req = '0;
    repeat (4) step();
    mask = 8'hFF;
    repeat (4) step();
    done = 1'b1; step(); done = 1'b0;

    // Random traffic, with done sometimes arriving and sometimes not.
    for (int c = 0; c < 3000; c++) begin
      req  = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
      mask = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
      done = ($urandom_range(0, 2) == 0);
      step();
    end
    // Requests held constantly with immediate done, to exercise grant rotation.
    mask = '1;
    for (int c = 0; c < 40; c++) begin
      req = 8'h81; done = 1'b1; step();
    end
    req = '0; done = 1'b0;
    repeat (12) step();

    // Assert reset asynchronously in the middle of a service.
    req = 8'h10; step(); req = '0;
    for (int i = 0; i < 10 && !irq; i++) step();
    chk("wait_irq", irq, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_irq", irq, 0);
    chk("async_ack", ack, 0);
    chk("async_pending", pending, 0);
    chk("async_irq_id", irq_id, 0);
    step(); step();
    reset_n = 1'b1;
    repeat (8) step();
    chk("left_grants", exp_grant.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/intr_ctrl_vectored.md
# intr_ctrl_vectored

Parametrised vectored interrupt controller for NINTR request lines. It provides sticky pending latches, a per-channel mask, an ack/done service handshake, and a service-timeout watchdog. Arbitration is fixed-priority, or round-robin when compiled in. It sits between peripheral interrupt sources and the CPU/sequencer, which services one interrupt at a time.

## Interface
- NINTR, 8: number of interrupt channels, 2..32.
- TIMEOUT, 64: cycles allowed in SERVICE without `done` before abort. 0 disables the watchdog.
- ID_W, $clog2(NINTR): derived localparam, not overridable.

Ports (clock and reset first):
- clk  in  1  clock. All logic is rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  NINTR  level requests, sampled every cycle.
- mask  in  NINTR  1 = channel enabled; 0 = pending held but not arbitrated.
- done  in  1  service-complete strobe from the handler.
- irq  out  1  interrupt to the handler; high throughout SERVICE.
- irq_id  out  ID_W  index of the granted channel; valid while irq=1.
- ack  out  NINTR  one-hot grant to the source; equals 1<<irq_id while irq=1, else 0.
- pending  out  NINTR  current pending register (status).
- timeout_err  out  1  one-cycle pulse on watchdog abort.

## Operation
- Pending update, every cycle: pending_next = (pending & ~clr) | req. `clr` is the grant one-hot in the ARB cycle and 0 otherwise. If a request and its clear coincide, the set wins.
- Eligible channels: pending & mask.
- State machine, one-hot encoded:
  - IDLE: if eligible != 0, go to ARB. Otherwise stay.
  - ARB: the arbiter picks winner w from eligible. On the next edge: irq=1, irq_id=w, ack=1<<w, pending[w] cleared, timer=0, state SERVICE. If eligible became 0 (mask dropped), return to IDLE with no grant.
  - SERVICE: hold irq/irq_id/ack.
    - done=1: irq=0, ack=0, irq_id holds its last value, state IDLE.
    - Else, if TIMEOUT != 0 and timer == TIMEOUT-1: same deassertion as `done`, plus timeout_err=1 for one cycle, state IDLE. The granted interrupt is dropped, not re-pended.
    - Else timer increments.
- `done` outside SERVICE is ignored.
- `done` and watchdog expiry in the same cycle: `done` wins and no timeout_err is raised.
- Changing `mask` during SERVICE never aborts the current grant.
- Masked pending bits are retained. Unmasking later makes them eligible.
- Fixed priority: the highest eligible index wins.
- Timer width: $clog2(TIMEOUT+1). It never wraps because it is reset on SERVICE entry.

## Timing
- Reset values: irq=0, irq_id=0, ack=0, pending=0, timeout_err=0, state IDLE, timer=0, rr pointer=0.
- Reset asserted mid-SERVICE drops everything immediately and asynchronously.
- Latency:
  - req high at edge E0 → pending set at E0.
  - ARB entered at E1.
  - irq/ack high after E2.
- `done` sampled at edge Ed → irq/ack low after Ed. The earliest next irq is after Ed+2.
- Watchdog: irq stays high for exactly TIMEOUT cycles when `done` never arrives. timeout_err is high in the cycle after the last SERVICE cycle, coincident with irq=0.
- The back-to-back service gap is 2 cycles (IDLE, ARB).

## Configuration
- INTC_ROUND_ROBIN_EN defined:
  - Arbitration scans eligible bits from rr pointer upward, wrapping modulo NINTR. The first set bit wins.
  - The pointer updates to (w+1) mod NINTR on SERVICE exit, whether by done or by timeout.
- INTC_ROUND_ROBIN_EN undefined:
  - Fixed priority, highest index wins.
  - No pointer register exists.

## Structure
- Package intr_ctrl_pkg holds:
  - state encodings IDLE=3'b001, ARB=3'b010, SERVICE=3'b100;
  - the state typedef;
  - helper function onehot(id).
- Sub-module intr_arbiter (NINTR param) is purely combinational:
  - inputs: eligible, ptr;
  - outputs: winner id, valid;
  - it ignores ptr when INTC_ROUND_ROBIN_EN is undefined.
- The top level owns the pending, FSM, timer and pointer registers.

## Test plan
- Single request: NINTR=8, mask=8'hFF, req[3] pulses for 1 cycle → irq=1, irq_id=3, ack=8'h08 two cycles later; done pulse → irq=0 next cycle; pending=0.
- Fixed priority: req=8'h24 simultaneously → grant id 5 first, then id 2 after done; pending=8'h04 during the first service.
- Round-robin (macro on): req held at 8'h81 continuously with immediate done each time → grants alternate 0,7,0,7.
- Mask: req[6] pulse with mask[6]=0 → no irq, pending[6]=1; set mask[6]=1 → irq_id=6 two cycles later.
- Timeout: TIMEOUT=4, grant id 1, done never arrives → irq high exactly 4 cycles, then timeout_err pulses, pending[1]=0. Repeat with done on the 4th cycle → no timeout_err.
- Async reset: assert reset_n=0 mid-SERVICE → all outputs 0 immediately. After release, nothing fires until a new req.
